// File: rtl/div_arbiter.sv
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module div_arbiter_rsp_slot #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_err,
  input  logic [DATA_WIDTH-1:0] load_q,
  input  logic                  consume,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  err
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= load_q;
      err   <= load_err;
    end else if (consume) begin
      valid <= 1'b0;
      err   <= 1'b0;
    end
  end
endmodule

module div_arbiter #(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_q,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_q,
  output logic                  rsp1_err,
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_a,
  output logic [DATA_WIDTH-1:0] div_b,
  input  logic                  div_done,
  input  logic [DATA_WIDTH-1:0] div_q
);
  localparam int NUM_PORTS = 2;
  localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(64'h7FF8_0000_0000_0000);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t                               state, state_nxt;
  logic [NUM_PORTS-1:0]                 req_valid, grant, rsp_rdy;
  logic [NUM_PORTS-1:0]                 slot_load, slot_consume, slot_valid, slot_err;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] slot_q;
  logic                                 tag, last_grant, grant_idx, accept, timeout, load_err;
  logic [DATA_WIDTH-1:0]                load_q;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_rdy   = {rsp1_ready, rsp0_ready};

  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      if (&req_valid) grant = last_grant ? 2'b01 : 2'b10;
      else            grant = req_valid;
    end
  end

  assign accept    = |grant;
  assign grant_idx = grant[1];

`ifdef DIV_WATCHDOG_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst)                 wd_cnt <= '0;
    else if (state == ISSUE) wd_cnt <= '0;
    else if (state == WAIT)  wd_cnt <= wd_cnt + 16'd1;
  end

  assign timeout = (state == WAIT) && (wd_cnt == 16'(DIV_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (div_done || timeout) state_nxt = RESP;
      RESP:  if (slot_valid[tag] && rsp_rdy[tag]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_start    = 1'b0;
    slot_load    = '0;
    slot_consume = '0;
    load_err     = 1'b0;
    load_q       = div_q;
    case (state)
      ISSUE: div_start = 1'b1;
      WAIT: begin
        if (div_done) begin
          slot_load[tag] = 1'b1;
        end else if (timeout) begin
          slot_load[tag] = 1'b1;
          load_err       = 1'b1;
          load_q         = QNAN;
        end
      end
      RESP:    slot_consume[tag] = rsp_rdy[tag];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_a      <= '0;
      div_b      <= '0;
      tag        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        div_a <= grant_idx ? req1_a : req0_a;
        div_b <= grant_idx ? req1_b : req0_b;
        tag   <= grant_idx;
      end
      if (state == RESP && slot_consume[tag]) last_grant <= tag;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
    div_arbiter_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (slot_load[p]),
      .load_err (load_err),
      .load_q   (load_q),
      .consume  (slot_consume[p]),
      .valid    (slot_valid[p]),
      .q        (slot_q[p]),
      .err      (slot_err[p])
    );
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = slot_valid[0];
  assign rsp1_valid = slot_valid[1];
  assign rsp0_q     = slot_q[0];
  assign rsp1_q     = slot_q[1];
  assign rsp0_err   = slot_err[0];
  assign rsp1_err   = slot_err[1];
endmodule

// File: tb/tb_div_arbiter.sv
`timescale 1ns/1ps

module tb_div_arbiter;
  localparam int DW = 64;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [DW-1:0] rsp0_q, rsp1_q;
  logic          rsp0_err, rsp1_err;
  logic          div_start, div_done;
  logic [DW-1:0] div_a, div_b, div_q;

  always #1 clk = ~clk;

  div_arbiter #(.DIV_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_q(rsp0_q), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_q(rsp1_q), .rsp1_err(rsp1_err),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_q(div_q)
  );

  int unsigned   mcnt = 0;
  logic [DW-1:0] mq = '0;
  logic          mute = 1'b0, spur = 1'b0;
  logic [DW-1:0] spur_q = 64'hDEAD_BEEF_0BAD_F00D;

  always @(posedge clk) begin
    if (div_start) begin
      mcnt <= D;
      mq   <= $realtobits($bitstoreal(div_a) / $bitstoreal(div_b));
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign div_done = (!mute && mcnt == 1) || spur;
  assign div_q    = spur ? spur_q : mq;

  int            n_chk = 0, n_fail = 0;
  logic          pending [2];
  logic [DW-1:0] pa [2], pb [2];
  int            last_g = 1;
  logic [DW-1:0] last_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rsp_v(input int p);
    return (p == 1) ? rsp1_valid : rsp0_valid;
  endfunction
  function automatic logic [DW-1:0] rsp_q(input int p);
    return (p == 1) ? rsp1_q : rsp0_q;
  endfunction
  function automatic logic rsp_e(input int p);
    return (p == 1) ? rsp1_err : rsp0_err;
  endfunction

  function automatic logic [DW-1:0] rnd_real(input bit divisor);
    real r;
    r = real'($urandom_range(1, 1000000)) / 16.0;
    if (!divisor && $urandom_range(0, 1) == 1) r = -r;
    return $realtobits(r);
  endfunction

  task automatic apply();
    req0_valid = pending[0]; req0_a = pa[0]; req0_b = pb[0];
    req1_valid = pending[1]; req1_a = pa[1]; req1_b = pb[1];
  endtask

  task automatic new_req(input int p);
    pending[p] = 1'b1;
    pa[p] = rnd_real(1'b0);
    pb[p] = rnd_real(1'b1);
  endtask

  task automatic set_rdy(input int p, input logic v);
    if (p == 1) rsp1_ready = v; else rsp0_ready = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pending[0] = 1'b0; pending[1] = 1'b0;
    apply();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0; spur = 1'b0; mute = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_g = 1;
  endtask

  task automatic get_grant(output int g, input bit spur_issue);
    int exp_g, n;
    exp_g = (pending[0] && pending[1]) ? 1 - last_g : (pending[0] ? 0 : 1);
    g = -1; n = 0;
    apply();
    while (g < 0 && n < 40) begin
      #0.2;
      chk("ready_onehot", req0_ready & req1_ready, 0);
      if (req0_ready)      g = 0;
      else if (req1_ready) g = 1;
      else begin @(negedge clk); n++; end
    end
    if (g < 0) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    chk("grant_port", g, exp_g);
    @(negedge clk);
    pending[g] = 1'b0;
    apply();
    if (spur_issue) spur = 1'b1;
    chk("div_start", div_start, 1);
    chk("div_a", div_a, pa[g]);
    chk("div_b", div_b, pb[g]);
  endtask

  task automatic serve(input int hold, input bit raise_other, input bit spur_issue,
                       input bit spur_resp, output int g);
    int n;
    logic [DW-1:0] eq;
    get_grant(g, spur_issue);
    if (g < 0) return;
    eq = $realtobits($bitstoreal(pa[g]) / $bitstoreal(pb[g]));
    if (raise_other) begin new_req(1 - g); apply(); end
    n = 1;
    while (!rsp_v(g) && n < 60) begin
      @(negedge clk);
      spur = 1'b0;
      n++;
      chk("start_once", div_start, 0);
    end
    chk("latency", n, D + 2);
    chk("rsp_q", rsp_q(g), eq);
    chk("rsp_err", rsp_e(g), 0);
    chk("other_silent", rsp_v(1 - g), 0);
    last_q = rsp_q(g);
    for (int i = 0; i < hold; i++) begin
      spur = spur_resp && (i == 0);
      @(negedge clk);
      spur = 1'b0;
      chk("hold_valid", rsp_v(g), 1);
      chk("hold_q", rsp_q(g), eq);
      chk("hold_no_grant", req0_ready | req1_ready, 0);
    end
    set_rdy(g, 1'b1);
    @(negedge clk);
    set_rdy(g, 1'b0);
    chk("consumed", rsp_v(g), 0);
    chk("err_clear", rsp_e(g), 0);
    last_g = g;
  endtask

  initial begin
    #50us;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, n;
    logic seen;
    pending[0] = 1'b0; pending[1] = 1'b0;
    pa[0] = '0; pb[0] = '0; pa[1] = '0; pb[1] = '0;
    do_reset();

    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);
    chk("rst_rsp0_q", rsp0_q, 0);
    chk("rst_rsp1_q", rsp1_q, 0);
    chk("rst_err", {rsp0_err, rsp1_err}, 0);

    pa[0] = 64'h4086_8000_0000_0000; pb[0] = 64'h4010_0000_0000_0000; pending[0] = 1'b1;
    serve(2, 1'b0, 1'b0, 1'b0, g);
    chk("t1_port", g, 0);
    chk("t1_q", last_q, 64'h4066_8000_0000_0000);

    do_reset();
    new_req(0); new_req(1);
    for (int k = 0; k < 4; k++) begin
      serve(1, 1'b0, 1'b0, 1'b0, g);
      chk("t2_order", g, k % 2);
      if (g >= 0) new_req(g);
    end
    pending[0] = 1'b0; pending[1] = 1'b0;
    apply();

    new_req(1);
    serve(20, 1'b1, 1'b0, 1'b0, g);
    chk("t3_port", g, 1);
    serve(0, 1'b0, 1'b0, 1'b0, g);
    chk("t3_next", g, 0);

    new_req(0);
    get_grant(g, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_g = 1;
    chk("t4_rsp0_valid", rsp0_valid, 0);
    chk("t4_div_a", div_a, 0);
    chk("t4_div_b", div_b, 0);
    chk("t4_rsp0_q", rsp0_q, 0);
    chk("t4_rsp1_q", rsp1_q, 0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= rsp0_valid | rsp1_valid | div_start;
    end
    chk("t4_killed", seen, 0);
    new_req(0);
    serve(1, 1'b0, 1'b0, 1'b0, g);
    chk("t4_next", g, 0);

    mute = 1'b1;
    new_req(0);
    get_grant(g, 1'b0);
`ifdef DIV_WATCHDOG_EN
    n = 1;
    while (!rsp0_valid && n < 60) begin @(negedge clk); n++; end
    chk("t5_latency", n, 16 + 2);
    chk("t5_err", rsp0_err, 1);
    chk("t5_qnan", rsp0_q, 64'h7FF8_0000_0000_0000);
    chk("t5_rsp1", rsp1_valid, 0);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    chk("t5_consumed", rsp0_valid, 0);
    chk("t5_err_clear", rsp0_err, 0);
    last_g = 0;
    mute = 1'b0;
`else
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= rsp0_valid | rsp1_valid;
    end
    chk("t5_no_rsp", seen, 0);
    chk("t5_err_tied", {rsp0_err, rsp1_err}, 0);
    do_reset();
`endif

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("t6_idle_valid", rsp0_valid | rsp1_valid, 0);
    chk("t6_idle_start", div_start, 0);
    new_req(1);
    serve(3, 1'b0, 1'b1, 1'b1, g);
    chk("t6_port", g, 1);

    for (int k = 0; k < 24; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pending[p] && $urandom_range(0, 1) == 1) new_req(p);
      if (!pending[0] && !pending[1]) new_req(int'($urandom_range(0, 1)));
      serve(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
